mul_issue_ctrl: RTL
===================

# mul_issue_ctrl

Issue/return controller that sits directly upstream of the iterative 64-cycle multiplier in the execute stage. It accepts a MUL/MULW request from the pipeline with raw register operands and converts them to magnitude operands plus a result-sign flag. It sequences the multiplier, captures its result into a holding register and returns it to the pipeline through a valid/ready handshake. It also owns flush and reset recovery, so the multiplier is never restarted while a previous computation is still counting.

## Interface
- WIDTH, 64: operand/result width.
- LATENCY, 64: multiplier iteration count; drain length is LATENCY+1.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset (`RstEnable`).
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- in_op  in  `SEL_DIV_WIDTH  `SEL_MUL or `SEL_MULW; any other code is ignored (not accepted).
- in_rs1, in_rs2  in  WIDTH  raw register operands.
- flush  in  1  pipeline kill; drops the in-flight or held request.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_result  out  WIDTH  product, MULW already sign-extended.
- busy  out  1  high in any state except IDLE; feeds the pipeline stall.
- mul_a, mul_b  out  WIDTH  magnitude operands to the multiplier.
- mul_sig  out  `SEL_DIV_WIDTH  op to the multiplier; `SEL_NONE except in BUSY.
- mul_sign  out  1  negate-result flag to the multiplier.
- mul_result  in  WIDTH  multiplier product.
- mul_stall  in  1  multiplier's own stall; high while computing.
- Integration: the multiplier's stall input is tied 0. Its clk/reset are shared with this block.

## Operation
- States: DRAIN, IDLE, BUSY, DONE. Counter cnt, 7 bits.
- Operand prep at accept, registered:
  - MUL: x=rs1, y=rs2.
  - MULW: x=sext(rs1[31:0]), y=sext(rs2[31:0]).
  - mul_a=|x|, mul_b=|y| (two's-complement negate if MSB set; 0x8000_0000_0000_0000 stays as-is and is treated as unsigned).
  - mul_sign = x[63]^y[63].
  - mul_a, mul_b, mul_sign and the latched op are stable from accept until leaving BUSY.
- IDLE:
  - in_ready=1.
  - in_valid && valid op && !flush -> BUSY, cnt=0.
- BUSY:
  - mul_sig = latched op; cnt increments each edge.
  - Entered at least one cycle and mul_stall==0 -> capture mul_result into the result register -> DONE.
  - flush -> DRAIN, cnt keeps counting.
- DONE:
  - out_valid=1; out_result = held register; mul_sig=`SEL_NONE.
  - out_ready -> IDLE.
  - flush -> IDLE (result dropped).
- DRAIN:
  - mul_sig=`SEL_NONE; in_ready=0; cnt increments.
  - cnt==LATENCY+1 -> IDLE, cnt=0.
  - Purpose: the multiplier ignores reset/sig mid-count, so DRAIN lets it reach END and return to INIT.
- Reset:
  - state=DRAIN, cnt=0, out_valid=0, in_ready=0, busy=1, mul_sig=`SEL_NONE, mul_a=mul_b=0, mul_sign=0, out_result=0.
  - Reset asserted in any state, including mid-BUSY, restarts this sequence.
- Simultaneous events:
  - flush beats accept and beats out_ready.
  - reset beats everything.
- No back-to-back accept: in_ready is low in DONE even when out_ready=1. The next accept is earliest the cycle after return to IDLE.

## Timing
- Accept at edge A.
  - Multiplier starts at A+1 and reaches END at A+64.
  - mul_stall falls after A+64; capture at A+65.
  - out_valid high from A+65; with out_ready=1, IDLE after A+66.
- Request-to-result latency is LATENCY+1 cycles after accept.
- Capture on mul_stall low only; cnt is not used for normal completion.
- The captured value must equal mul_result at edge A+65. The multiplier does not alter mul_c on the END->INIT edge.
- Post-reset: in_ready first high LATENCY+1 = 65 cycles after reset deasserts.
- Flush at any BUSY cycle k (cnt=k): IDLE after cnt reaches 65, i.e. 65-k further edges.
- Flush in DONE: IDLE next edge.

## Test plan
- Reset for 2 cycles, then release -> in_ready low for exactly 65 cycles, all other outputs at reset values.
- MUL rs1=3, rs2=5 accepted at A -> mul_a=3, mul_b=5, mul_sign=0; out_valid at A+65 with out_result=15.
- MUL rs1=-3 (0xFFFF_FFFF_FFFF_FFFD), rs2=5 -> mul_a=3, mul_sign=1, out_result=0xFFFF_FFFF_FFFF_FFF1.
- MULW rs1=0xDEAD_BEEF_7FFF_FFFF, rs2=2 -> mul_a=0x7FFF_FFFF, out_result=0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_result stable, mul_sig=`SEL_NONE, in_ready=0. Raising out_ready -> IDLE next edge.
- Flush at cnt=10 in BUSY, new MUL 7*6 pending -> no accept for 55 edges; then accepted, result 42 with correct latency. Repeat with reset at cnt=10 -> 65-cycle drain, then 42.

Source files
------------

// File: rtl/mul_issue_if.sv
// mul_issue_if: pipeline request/return and multiplier-side signals of the MUL issue controller
`ifndef SEL_DIV_WIDTH
`define SEL_DIV_WIDTH 4
`endif
`ifndef SEL_NONE
`define SEL_NONE 4'd0
`endif
`ifndef SEL_MUL
`define SEL_MUL 4'd1
`endif
`ifndef SEL_MULW
`define SEL_MULW 4'd2
`endif
interface mul_issue_if #(parameter int WIDTH = 64);
  logic                      in_valid;
  logic                      in_ready;
  logic [`SEL_DIV_WIDTH-1:0] in_op;
  logic [WIDTH-1:0]          in_rs1;
  logic [WIDTH-1:0]          in_rs2;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_result;
  logic                      busy;
  logic [WIDTH-1:0]          mul_a;
  logic [WIDTH-1:0]          mul_b;
  logic [`SEL_DIV_WIDTH-1:0] mul_sig;
  logic                      mul_sign;
  logic [WIDTH-1:0]          mul_result;
  logic                      mul_stall;
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, flush, out_ready, mul_result, mul_stall,
    output in_ready, out_valid, out_result, busy, mul_a, mul_b, mul_sig, mul_sign
  );
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, flush, out_ready, mul_result, mul_stall,
    input  in_ready, out_valid, out_result, busy, mul_a, mul_b, mul_sig, mul_sign
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues MUL/MULW to the iterative multiplier, returns the product, drains on flush/reset
module mul_issue_ctrl #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 64
) (
  input logic       clk,
  input logic       reset,
  mul_issue_if.slave bus
);
  typedef enum logic [1:0] {DRAIN, IDLE, BUSY, DONE} state_t;
  state_t           state, state_nxt;
  logic [6:0]       cnt, cnt_nxt;
  logic             op_ok, accept, capture, drain_end;
  logic [WIDTH-1:0] x, y;
  assign op_ok     = bus.in_op == `SEL_MUL || bus.in_op == `SEL_MULW;
  assign accept    = state == IDLE && bus.in_valid && op_ok && !bus.flush;
  // cnt != 0 skips the first BUSY edge, before the multiplier has raised its stall
  assign capture   = state == BUSY && cnt != 7'd0 && !bus.mul_stall && !bus.flush;
  // leave DRAIN on the edge where cnt would reach LATENCY+1; >= also covers a flush on the capture edge
  assign drain_end = state == DRAIN && cnt >= 7'(LATENCY);
  assign x = bus.in_op == `SEL_MULW ? {{(WIDTH-32){bus.in_rs1[31]}}, bus.in_rs1[31:0]} : bus.in_rs1;
  assign y = bus.in_op == `SEL_MULW ? {{(WIDTH-32){bus.in_rs2[31]}}, bus.in_rs2[31:0]} : bus.in_rs2;
  // next state and counter; flush wins over accept, capture and out_ready
  always_comb begin
    state_nxt = state == IDLE  ? (accept ? BUSY : IDLE) :
                state == BUSY  ? (bus.flush ? DRAIN : capture ? DONE : BUSY) :
                state == DONE  ? ((bus.flush || bus.out_ready) ? IDLE : DONE) :
                                 (drain_end ? IDLE : DRAIN);
    cnt_nxt   = (accept || drain_end) ? 7'd0 :
                (state == BUSY || state == DRAIN) ? cnt + 7'd1 : cnt;
  end
  // state, registered handshake outputs, operand prep at accept and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= DRAIN;
      cnt            <= 7'd0;
      bus.in_ready   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.busy       <= 1'b1;
      bus.mul_sig    <= `SEL_NONE;
      bus.mul_a      <= '0;
      bus.mul_b      <= '0;
      bus.mul_sign   <= 1'b0;
      bus.out_result <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.in_ready  <= state_nxt == IDLE;
      bus.out_valid <= state_nxt == DONE;
      bus.busy      <= state_nxt != IDLE;
      bus.mul_sig   <= state_nxt == BUSY ? (accept ? bus.in_op : bus.mul_sig) : `SEL_NONE;
      if (accept) begin
        bus.mul_a    <= x[WIDTH-1] ? -x : x;
        bus.mul_b    <= y[WIDTH-1] ? -y : y;
        bus.mul_sign <= x[WIDTH-1] ^ y[WIDTH-1];
      end
      if (capture) bus.out_result <= bus.mul_result;
    end
  end
endmodule
